axilwb_arbiter: RTL and testbench
=================================

Name: axilwb_arbiter

Overview:
- Two-master Wishbone arbiter that completes the AXI-lite to Wishbone bridge.
- Master A is the AXI-lite read-channel bridge; master B is the AXI-lite write-channel bridge. Both share one pipelined Wishbone slave port.
- Grants the bus for whole bus cycles (CYC-to-CYC) using round-robin.
- Routes ACK/ERR/STALL only to the owner, and aborts hung cycles with a watchdog that returns ERR to the owner.

Parameters:
- AW, 26, Wishbone word-address width.
- DW, 32, data width; the SEL width is DW/8.
- TIMEOUT, 1024, watchdog limit in cycles; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock
- w_reset  in  1  synchronous active-high reset
- i_a_cyc, i_a_stb, i_a_we  in  1 each  master A request
- i_a_addr  in  AW  master A address
- i_a_data  in  DW  master A write data
- i_a_sel  in  DW/8  master A byte select
- o_a_stall, o_a_ack, o_a_err  out  1 each  master A response
- o_a_data  out  DW  master A read data
- i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data, i_b_sel  in  as for A  master B request
- o_b_stall, o_b_ack, o_b_err, o_b_data  out  as for A  master B response
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  slave request
- o_wb_addr  out  AW  slave address
- o_wb_data  out  DW  slave write data
- o_wb_sel  out  DW/8  slave byte select
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave response
- i_wb_data  in  DW  slave read data

Behaviour:
- Reset and clocking: reset is w_reset, synchronous, active-high; clock is i_clk.
- Reset state: state=IDLE, last_owner=B (so A wins the first tie), watchdog=0.
- Reset values of outputs: o_wb_cyc=0, o_wb_stb=0, all acks/errs=0, o_a_stall=o_b_stall=1.
- Reset mid-cycle: all of the above take effect on the next edge; the owner receives no ack/err for the aborted cycle.
- States and transitions:
  - IDLE. A requester is one with cyc=1. If only A requests, go to GNT_A next edge; only B, go to GNT_B. If both request, grant the one that is not last_owner.
  - GNT_A and GNT_B: stay while the owner's cyc=1.
  - Owner drops cyc with the other master requesting: go directly to the other's GNT state. Otherwise go to IDLE. Update last_owner on every release.
  - ABORT: entered from GNT_x on watchdog expiry. Stays until the owner drops cyc, then goes to IDLE.
- Grant latency:
  - The grant is registered: a request first seen at cycle n appears on o_wb_* at n+1.
  - In GNT_x, the o_wb_* request signals are combinational pass-through of master x.
  - o_wb_cyc = x_cyc in GNT_x, else 0. o_wb_stb = x_cyc & x_stb in GNT_x, else 0.
  - Address, data, sel and we are muxed from the owner; they hold the B values when not granted.
- Response routing:
  - Owner x: o_x_stall = i_wb_stall, o_x_ack = i_wb_ack, o_x_err = i_wb_err.
  - Non-owner: stall=1, ack=0, err=0, always.
  - o_a_data and o_b_data are both wired to i_wb_data.
  - A slave ack/err arriving while in IDLE or ABORT is dropped.
- Watchdog:
  - Counter width is clog2(TIMEOUT+1).
  - Cleared when o_wb_cyc=0, or on i_wb_ack, or on i_wb_err. Otherwise increments while o_wb_cyc=1.
  - When counter == TIMEOUT-1 with no ack/err that cycle: pulse o_x_err to the owner for one cycle and enter ABORT.
  - In ABORT: o_wb_cyc=0, owner stall=1, owner ack=0.
- Simultaneous events:
  - Ack and expiry in the same cycle: the ack wins and the counter clears.
  - Slave err while granted: pass it through; the owner is expected to drop cyc, and arbitration proceeds normally.
  - Owner drops cyc in the same cycle ack arrives: the ack is still delivered.
- Outstanding ack invariant: the grant never changes while the owner's cyc=1, so outstanding acks are never misrouted.

Test Plan:
- A only: A sends cyc/stb, addr=0x10, we=0. o_wb_stb rises 1 cycle later with addr 0x10. Slave acks with data 0xDEADBEEF: o_a_ack=1, o_a_data=0xDEADBEEF, o_b_ack=0. A drops cyc: IDLE on the next edge.
- Contention after reset: A and B raise cyc in the same cycle. A is granted and o_b_stall=1 throughout. When A releases, B is granted on the next edge with we=1 and B's data/sel on o_wb_*.
- Round-robin: A and B request continuously, each doing a 1-beat cycle. Grants alternate A,B,A,B with no IDLE cycles between them.
- Watchdog: set TIMEOUT=8; B granted, slave never acks. o_b_err pulses exactly 8 cycles after o_wb_cyc rose, then o_wb_cyc=0. A pending request is granted only after B drops cyc.
- Error routing: A granted and slave returns i_wb_err. o_a_err=1 and o_b_err=0, the watchdog clears, and A is released normally.
- Reset mid-cycle: assert w_reset while in GNT_B with 2 acks outstanding. Next cycle: o_wb_cyc=0 and state IDLE. A subsequent ack is not delivered to either master.

Source files
------------

// File: rtl/axilwb_arbiter.sv
// Two-master round-robin Wishbone arbiter joining the AXI-lite read (A) and
// write (B) bridges onto one pipelined slave port, with a hung-cycle watchdog.
module axilwb_arbiter #(
  parameter int unsigned AW      = 26,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              w_reset,
  // master A (read-channel bridge)
  input  logic              i_a_cyc,
  input  logic              i_a_stb,
  input  logic              i_a_we,
  input  logic [AW-1:0]     i_a_addr,
  input  logic [DW-1:0]     i_a_data,
  input  logic [DW/8-1:0]   i_a_sel,
  output logic              o_a_stall,
  output logic              o_a_ack,
  output logic              o_a_err,
  output logic [DW-1:0]     o_a_data,
  // master B (write-channel bridge)
  input  logic              i_b_cyc,
  input  logic              i_b_stb,
  input  logic              i_b_we,
  input  logic [AW-1:0]     i_b_addr,
  input  logic [DW-1:0]     i_b_data,
  input  logic [DW/8-1:0]   i_b_sel,
  output logic              o_b_stall,
  output logic              o_b_ack,
  output logic              o_b_err,
  output logic [DW-1:0]     o_b_data,
  // shared slave port
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DW-1:0]     o_wb_data,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic              i_wb_err,
  input  logic [DW-1:0]     i_wb_data
);

  localparam int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  localparam bit          WD_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_last_b;   // last released owner was B
  logic          r_owner_b;  // current (or aborted) owner is B
  logic [CW-1:0] r_wdog;
  logic          r_wd_err;   // one-cycle watchdog error, first ABORT cycle

  logic w_gnt_a;
  logic w_gnt_b;
  logic w_abort;
  logic w_wb_cyc;
  logic w_resp;
  logic w_expire;
  logic w_own_cyc;

  assign w_gnt_a   = (r_state == S_GNT_A);
  assign w_gnt_b   = (r_state == S_GNT_B);
  assign w_abort   = (r_state == S_ABORT);
  assign w_own_cyc = r_owner_b ? i_b_cyc : i_a_cyc;
  assign w_wb_cyc  = (w_gnt_a & i_a_cyc) | (w_gnt_b & i_b_cyc);
  assign w_resp    = i_wb_ack | i_wb_err;
  assign w_expire  = WD_EN && w_wb_cyc && !w_resp && (r_wdog == WD_LAST);

  // Request pass-through from the owner; payload rests on B when ungranted
  assign o_wb_cyc  = w_wb_cyc;
  assign o_wb_stb  = (w_gnt_a & i_a_cyc & i_a_stb) | (w_gnt_b & i_b_cyc & i_b_stb);
  assign o_wb_we   = w_gnt_a ? i_a_we   : i_b_we;
  assign o_wb_addr = w_gnt_a ? i_a_addr : i_b_addr;
  assign o_wb_data = w_gnt_a ? i_a_data : i_b_data;
  assign o_wb_sel  = w_gnt_a ? i_a_sel  : i_b_sel;

  // Responses reach only the owner; acks in IDLE/ABORT fall on the floor
  assign o_a_stall = w_gnt_a ? i_wb_stall : 1'b1;
  assign o_a_ack   = w_gnt_a & i_wb_ack;
  assign o_a_err   = (w_gnt_a & i_wb_err) | (w_abort & r_wd_err & ~r_owner_b);
  assign o_b_stall = w_gnt_b ? i_wb_stall : 1'b1;
  assign o_b_ack   = w_gnt_b & i_wb_ack;
  assign o_b_err   = (w_gnt_b & i_wb_err) | (w_abort & r_wd_err & r_owner_b);
  assign o_a_data  = i_wb_data;
  assign o_b_data  = i_wb_data;

  // Arbitration FSM plus watchdog; the grant only moves once the owner drops cyc
  always_ff @(posedge i_clk) begin
    if (w_reset) begin
      r_state   <= S_IDLE;
      r_last_b  <= 1'b1;
      r_owner_b <= 1'b0;
      r_wdog    <= '0;
      r_wd_err  <= 1'b0;
    end else begin
      r_wd_err <= w_expire;

      if (!w_wb_cyc || w_resp || w_expire) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (i_a_cyc && (!i_b_cyc || r_last_b)) begin
            r_state   <= S_GNT_A;
            r_owner_b <= 1'b0;
          end else if (i_b_cyc) begin
            r_state   <= S_GNT_B;
            r_owner_b <= 1'b1;
          end
        end
        S_GNT_A: begin
          if (!i_a_cyc) begin
            r_last_b <= 1'b0;
            if (i_b_cyc) begin
              r_state   <= S_GNT_B;
              r_owner_b <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_expire) begin
            r_state <= S_ABORT;
          end
        end
        S_GNT_B: begin
          if (!i_b_cyc) begin
            r_last_b <= 1'b1;
            if (i_a_cyc) begin
              r_state   <= S_GNT_A;
              r_owner_b <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_expire) begin
            r_state <= S_ABORT;
          end
        end
        S_ABORT: begin
          if (!w_own_cyc) begin
            r_last_b <= r_owner_b;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilwb_arbiter.sv
// Bench for axilwb_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a cycle-level ownership model.
module tb_axilwb_arbiter;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  localparam logic [AW-1:0] A_ADDR = 26'h10;
  localparam logic [DW-1:0] A_DATA = 32'h1111_1111;
  localparam logic [SW-1:0] A_SEL  = 4'h3;
  localparam logic [AW-1:0] B_ADDR = 26'h20;
  localparam logic [DW-1:0] B_DATA = 32'hCAFE_F00D;
  localparam logic [SW-1:0] B_SEL  = 4'hF;
  localparam logic [DW-1:0] S_DATA = 32'hDEAD_BEEF;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic rst;
  logic a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data, wb_rdata;
  logic [SW-1:0] a_sel, b_sel;
  logic wb_ack, wb_stall, wb_err;

  logic oa_stall, oa_ack, oa_err, ob_stall, ob_ack, ob_err;
  logic [DW-1:0] oa_data, ob_data, owb_data;
  logic owb_cyc, owb_stb, owb_we;
  logic [AW-1:0] owb_addr;
  logic [SW-1:0] owb_sel;

  axilwb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .w_reset(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_data), .i_a_sel(a_sel),
    .o_a_stall(oa_stall), .o_a_ack(oa_ack), .o_a_err(oa_err), .o_a_data(oa_data),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_data), .i_b_sel(b_sel),
    .o_b_stall(ob_stall), .o_b_ack(ob_ack), .o_b_err(ob_err), .o_b_data(ob_data),
    .o_wb_cyc(owb_cyc), .o_wb_stb(owb_stb), .o_wb_we(owb_we), .o_wb_addr(owb_addr),
    .o_wb_data(owb_data), .o_wb_sel(owb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
  );

  typedef struct packed {
    logic cyc, stb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    logic a_stall, a_ack, a_err;
    logic [DW-1:0] a_data;
    logic b_stall, b_ack, b_err;
    logic [DW-1:0] b_data;
  } outs_t;

  // stim = {rst,a_cyc,a_stb,b_cyc,b_stb,ack,err,stall}
  // exp  = {cyc,stb,payload_from_a,a_ack,a_err,a_stall,b_ack,b_err,b_stall}
  typedef struct {
    logic [7:0] stim;
    logic [8:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // behavioural model: who owns the bus and how long it has gone unanswered
  int m_own;     // 0 none, 1 A, 2 B
  bit m_abort;
  int m_last;    // 1 A, 2 B
  int m_quiet;
  bit m_werr;

  function automatic outs_t sample();
    outs_t s;
    s.cyc = owb_cyc; s.stb = owb_stb; s.we = owb_we; s.addr = owb_addr;
    s.data = owb_data; s.sel = owb_sel;
    s.a_stall = oa_stall; s.a_ack = oa_ack; s.a_err = oa_err; s.a_data = oa_data;
    s.b_stall = ob_stall; s.b_ack = ob_ack; s.b_err = ob_err; s.b_data = ob_data;
    return s;
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_fixed();
    a_we = 1'b0; a_addr = A_ADDR; a_data = A_DATA; a_sel = A_SEL;
    b_we = 1'b1; b_addr = B_ADDR; b_data = B_DATA; b_sel = B_SEL;
    wb_rdata = S_DATA;
  endtask

  task automatic do_reset();
    a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0;
    wb_ack = 0; wb_err = 0; wb_stall = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic outs_t model_out();
    outs_t e;
    bit ga, gb;
    ga = !m_abort && m_own == 1;
    gb = !m_abort && m_own == 2;
    e.cyc  = (ga && a_cyc) || (gb && b_cyc);
    e.stb  = (ga && a_cyc && a_stb) || (gb && b_cyc && b_stb);
    e.we   = ga ? a_we : b_we;
    e.addr = ga ? a_addr : b_addr;
    e.data = ga ? a_data : b_data;
    e.sel  = ga ? a_sel : b_sel;
    e.a_stall = ga ? wb_stall : 1'b1;
    e.a_ack   = ga && wb_ack;
    e.a_err   = (ga && wb_err) || (m_abort && m_own == 1 && m_werr);
    e.b_stall = gb ? wb_stall : 1'b1;
    e.b_ack   = gb && wb_ack;
    e.b_err   = (gb && wb_err) || (m_abort && m_own == 2 && m_werr);
    e.a_data  = wb_rdata;
    e.b_data  = wb_rdata;
    return e;
  endfunction

  task automatic model_reset();
    m_own = 0; m_abort = 0; m_last = 2; m_quiet = 0; m_werr = 0;
  endtask

  task automatic model_step();
    bit own_cyc, oth_cyc;
    if (rst) begin
      model_reset();
      return;
    end
    m_werr = 0;
    own_cyc = (m_own == 1) ? a_cyc : (m_own == 2) ? b_cyc : 1'b0;
    oth_cyc = (m_own == 1) ? b_cyc : a_cyc;
    if (m_abort) begin
      if (!own_cyc) begin
        m_last = m_own; m_own = 0; m_abort = 0;
      end
    end else if (m_own == 0) begin
      m_quiet = 0;
      if (a_cyc && b_cyc) m_own = (m_last == 2) ? 1 : 2;
      else if (a_cyc) m_own = 1;
      else if (b_cyc) m_own = 2;
    end else if (!own_cyc) begin
      m_last = m_own;
      m_own = oth_cyc ? 3 - m_own : 0;
      m_quiet = 0;
    end else if (wb_ack || wb_err) begin
      m_quiet = 0;
    end else if (m_quiet + 1 == int'(TO)) begin
      m_abort = 1; m_werr = 1; m_quiet = 0;
    end else begin
      m_quiet++;
    end
  endtask

  vec_t tbl[$];

  initial begin
    outs_t e;
    int k;
    int rate;

    rst = 1'b1;
    set_fixed();
    do_reset();

    // reset state, A alone, contention, round-robin, error routing
    tbl.push_back('{8'b0_00_00_000, 9'b000_001_001});
    tbl.push_back('{8'b0_11_00_000, 9'b000_001_001});
    tbl.push_back('{8'b0_11_00_000, 9'b111_000_001});
    tbl.push_back('{8'b0_10_00_100, 9'b101_100_001});
    tbl.push_back('{8'b0_00_00_000, 9'b001_000_001});
    tbl.push_back('{8'b0_00_00_000, 9'b000_001_001});
    tbl.push_back('{8'b1_00_00_000, 9'b000_001_001});
    tbl.push_back('{8'b0_11_11_000, 9'b000_001_001});
    tbl.push_back('{8'b0_11_11_000, 9'b111_000_001});
    tbl.push_back('{8'b0_11_11_100, 9'b111_100_001});
    tbl.push_back('{8'b0_00_11_000, 9'b001_000_001});
    tbl.push_back('{8'b0_00_11_000, 9'b110_001_000});
    tbl.push_back('{8'b0_00_10_100, 9'b100_001_100});
    tbl.push_back('{8'b0_11_00_000, 9'b000_001_000});
    tbl.push_back('{8'b0_11_11_000, 9'b111_000_001});
    tbl.push_back('{8'b0_10_11_100, 9'b101_100_001});
    tbl.push_back('{8'b0_00_11_000, 9'b001_000_001});
    tbl.push_back('{8'b0_11_11_000, 9'b110_001_000});
    tbl.push_back('{8'b0_11_10_100, 9'b100_001_100});
    tbl.push_back('{8'b0_11_00_000, 9'b000_001_000});
    tbl.push_back('{8'b0_11_11_001, 9'b111_001_001});
    tbl.push_back('{8'b0_10_11_010, 9'b101_010_001});
    tbl.push_back('{8'b0_00_11_000, 9'b001_000_001});
    tbl.push_back('{8'b0_00_11_000, 9'b110_001_000});
    tbl.push_back('{8'b0_00_00_000, 9'b000_001_000});
    tbl.push_back('{8'b0_00_00_000, 9'b000_001_001});

    foreach (tbl[i]) begin
      {rst, a_cyc, a_stb, b_cyc, b_stb, wb_ack, wb_err, wb_stall} = tbl[i].stim;
      #2;
      e.cyc = tbl[i].exp[8];
      e.stb = tbl[i].exp[7];
      e.we   = tbl[i].exp[6] ? 1'b0   : 1'b1;
      e.addr = tbl[i].exp[6] ? A_ADDR : B_ADDR;
      e.data = tbl[i].exp[6] ? A_DATA : B_DATA;
      e.sel  = tbl[i].exp[6] ? A_SEL  : B_SEL;
      {e.a_ack, e.a_err, e.a_stall} = tbl[i].exp[5:3];
      {e.b_ack, e.b_err, e.b_stall} = tbl[i].exp[2:0];
      e.a_data = S_DATA;
      e.b_data = S_DATA;
      check($sformatf("vec%0d", i), e);
      tick();
    end

    // watchdog: B hangs, A waits behind it
    do_reset();
    b_cyc = 1; b_stb = 1; wb_stall = 1;
    #2;
    tick();
    a_cyc = 1; a_stb = 1;
    k = 0;
    while (k < 20) begin
      #2;
      if (ob_err) break;
      tick();
      k++;
    end
    check_val("wd_latency", k, int'(TO));
    check_val("wd_cyc_low", int'(owb_cyc), 0);
    check_val("wd_a_err", int'(oa_err), 0);
    tick();
    #2;
    check_val("wd_err_pulse", int'(ob_err), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      check_val("wd_hold_cyc", int'(owb_cyc), 0);
      check_val("wd_hold_astall", int'(oa_stall), 1);
    end
    tick();
    b_cyc = 0; b_stb = 0;
    #2;
    check_val("wd_drop_cyc", int'(owb_cyc), 0);
    tick();
    #2;
    check_val("wd_idle_cyc", int'(owb_cyc), 0);
    tick();
    #2;
    check_val("wd_a_granted", int'(owb_cyc), 1);
    check_val("wd_a_addr", int'(owb_addr), int'(A_ADDR));

    // reset while B has two beats outstanding
    do_reset();
    b_cyc = 1; b_stb = 1; wb_stall = 0;
    #2;
    tick();
    #2;
    check_val("rst_beat1_stb", int'(owb_stb), 1);
    tick();
    #2;
    check_val("rst_beat2_stb", int'(owb_stb), 1);
    tick();
    rst = 1; b_stb = 0;
    #2;
    tick();
    rst = 0; b_cyc = 0; wb_ack = 1;
    #2;
    check_val("rst_cyc_low", int'(owb_cyc), 0);
    check_val("rst_b_ack", int'(ob_ack), 0);
    check_val("rst_a_ack", int'(oa_ack), 0);
    tick();
    #2;
    check_val("rst_late_b_ack", int'(ob_ack), 0);
    check_val("rst_late_stall", int'(ob_stall), 1);
    wb_ack = 0;

    // random traffic against the model
    do_reset();
    model_reset();
    rate = 60;
    for (int cyc_n = 0; cyc_n < 4000; cyc_n++) begin
      if (cyc_n % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 0;
          1: rate = 15;
          default: rate = 60;
        endcase
      end
      rst = ($urandom_range(0, 199) == 0);
      a_cyc = a_cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      b_cyc = b_cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      a_stb = 1'($urandom);
      b_stb = 1'($urandom);
      a_we = 1'($urandom);
      b_we = 1'($urandom);
      a_addr = AW'($urandom);
      b_addr = AW'($urandom);
      a_data = $urandom;
      b_data = $urandom;
      a_sel = SW'($urandom);
      b_sel = SW'($urandom);
      wb_ack = (int'($urandom_range(0, 99)) < rate);
      wb_err = ($urandom_range(0, 99) < 3);
      wb_stall = ($urandom_range(0, 9) < 3);
      wb_rdata = $urandom;
      #2;
      check("rand", model_out());
      model_step();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
